// File: rtl/mpu_eth_rx_packer.sv
// mpu_eth_rx_packer: packs the MAC byte-wide receive stream into OUT_BYTES-wide packet beats,
// with max-length truncation, SOP/EOP recovery, merged per-packet error and saturating stats.
module mpu_eth_rx_packer #(
    parameter int OUT_BYTES = 4,
    parameter int MAX_LEN   = 1518,
    parameter int ERR_W     = 6,
    parameter int CNT_W     = 16
) (
    input  logic                         clk_clk,
    input  logic                         reset_reset,
    input  logic [7:0]                   receive_data,
    input  logic                         receive_valid,
    input  logic                         receive_startofpacket,
    input  logic                         receive_endofpacket,
    input  logic [ERR_W-1:0]             receive_error,
    output logic                         receive_ready,
    output logic [OUT_BYTES*8-1:0]       pkt_data,
    output logic                         pkt_valid,
    input  logic                         pkt_ready,
    output logic                         pkt_startofpacket,
    output logic                         pkt_endofpacket,
    output logic [$clog2(OUT_BYTES)-1:0] pkt_empty,
    output logic                         pkt_error,
    output logic [CNT_W-1:0]             stat_pkt_cnt,
    output logic [CNT_W-1:0]             stat_err_cnt,
    output logic [CNT_W-1:0]             stat_drop_cnt
);

    localparam int LANE_W = $clog2(OUT_BYTES);
    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int DW     = OUT_BYTES * 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_IN_PKT,
        S_DISCARD
    } state_t;

    state_t              r_state;
    logic [DW-1:0]       r_acc;
    logic [LANE_W-1:0]   r_lane;
    logic [LEN_W-1:0]    r_len;
    logic                r_first;

    logic [DW-1:0]       r_pkt_data;
    logic                r_pkt_valid;
    logic                r_pkt_sop;
    logic                r_pkt_eop;
    logic [LANE_W-1:0]   r_pkt_empty;
    logic                r_pkt_err;
    logic [CNT_W-1:0]    r_pkt_cnt;
    logic [CNT_W-1:0]    r_err_cnt;
    logic [CNT_W-1:0]    r_drop_cnt;

    logic                w_ready;
    logic                w_take;
    logic                w_eop_hs;

    logic                w_load;
    logic [DW-1:0]       w_beat_data;
    logic                w_beat_sop;
    logic                w_beat_eop;
    logic [LANE_W-1:0]   w_beat_emp;
    logic                w_beat_err;
    logic                w_drop;
    state_t              w_state_nx;
    logic [DW-1:0]       w_acc_nx;
    logic [LANE_W-1:0]   w_lane_nx;
    logic [LEN_W-1:0]    w_len_nx;
    logic                w_first_nx;

    logic                w_wr;
    logic [DW-1:0]       w_wr_acc;
    logic [LANE_W-1:0]   w_wr_lane;
    logic [LEN_W-1:0]    w_wr_len;
    logic                w_wr_first;
    logic [DW-1:0]       w_ins;
    logic [LEN_W-1:0]    w_len_inc;
    logic                w_trunc;
    logic                w_end;

    function automatic logic [DW-1:0] f_insert(input logic [DW-1:0]     acc,
                                               input logic [LANE_W-1:0] lane,
                                               input logic [7:0]        b);
        logic [DW-1:0] v;
        v = acc;
        for (int i = 0; i < OUT_BYTES; i++) begin
            if (lane == LANE_W'(i)) v[(OUT_BYTES-1-i)*8 +: 8] = b;
        end
        return v;
    endfunction

    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_ready  = !reset_reset && !(r_pkt_valid && !pkt_ready);
    assign w_take   = receive_valid && w_ready;
    assign w_eop_hs = r_pkt_valid && pkt_ready && r_pkt_eop;

    always_comb begin
        w_load      = 1'b0;
        w_beat_data = '0;
        w_beat_sop  = 1'b0;
        w_beat_eop  = 1'b0;
        w_beat_emp  = '0;
        w_beat_err  = 1'b0;
        w_drop      = 1'b0;
        w_state_nx  = r_state;
        w_acc_nx    = r_acc;
        w_lane_nx   = r_lane;
        w_len_nx    = r_len;
        w_first_nx  = r_first;
        w_wr        = 1'b0;
        w_wr_acc    = r_acc;
        w_wr_lane   = r_lane;
        w_wr_len    = r_len;
        w_wr_first  = r_first;
        w_ins       = '0;
        w_len_inc   = '0;
        w_trunc     = 1'b0;
        w_end       = 1'b0;

        if (w_take) begin
            if (receive_startofpacket && r_state == S_IN_PKT) begin
                // Cut frame: flush what is held as a bad EOP beat; lane 0 means only a marker beat remains.
                w_load      = 1'b1;
                w_beat_data = r_acc;
                w_beat_sop  = r_first;
                w_beat_eop  = 1'b1;
                w_beat_err  = 1'b1;
                w_beat_emp  = (r_lane == '0) ? LANE_W'(OUT_BYTES - 1) : LANE_W'(0) - r_lane;
                if (receive_endofpacket) begin
                    // A single-byte frame cannot share the output register with the flush beat.
                    w_drop     = 1'b1;
                    w_state_nx = S_IDLE;
                    w_acc_nx   = '0;
                    w_lane_nx  = '0;
                    w_len_nx   = '0;
                    w_first_nx = 1'b0;
                end else begin
                    w_state_nx = S_IN_PKT;
                    w_acc_nx   = f_insert('0, '0, receive_data);
                    w_lane_nx  = LANE_W'(1);
                    w_len_nx   = LEN_W'(1);
                    w_first_nx = 1'b1;
                end
            end else if (receive_startofpacket) begin
                w_wr       = 1'b1;
                w_wr_acc   = '0;
                w_wr_lane  = '0;
                w_wr_len   = '0;
                w_wr_first = 1'b1;
            end else if (r_state == S_IN_PKT) begin
                w_wr = 1'b1;
            end else begin
                w_drop = 1'b1;
                if (r_state == S_DISCARD && receive_endofpacket) w_state_nx = S_IDLE;
            end
        end

        if (w_wr) begin
            w_ins     = f_insert(w_wr_acc, w_wr_lane, receive_data);
            w_len_inc = w_wr_len + 1'b1;
            w_trunc   = (w_len_inc == LEN_W'(MAX_LEN)) && !receive_endofpacket;
            w_end     = receive_endofpacket || w_trunc;
            if (w_wr_lane == LANE_W'(OUT_BYTES - 1) || w_end) begin
                w_load      = 1'b1;
                w_beat_data = w_ins;
                w_beat_sop  = w_wr_first;
                w_beat_eop  = w_end;
                w_beat_emp  = w_end ? LANE_W'(OUT_BYTES - 1) - w_wr_lane : '0;
                w_beat_err  = receive_endofpacket ? (|receive_error) : w_trunc;
                w_acc_nx    = '0;
                w_lane_nx   = '0;
                w_first_nx  = 1'b0;
                w_len_nx    = w_end ? '0 : w_len_inc;
                w_state_nx  = w_trunc ? S_DISCARD : (receive_endofpacket ? S_IDLE : S_IN_PKT);
            end else begin
                w_acc_nx   = w_ins;
                w_lane_nx  = w_wr_lane + 1'b1;
                w_len_nx   = w_len_inc;
                w_first_nx = w_wr_first;
                w_state_nx = S_IN_PKT;
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_lane      <= '0;
            r_len       <= '0;
            r_first     <= 1'b0;
            r_pkt_data  <= '0;
            r_pkt_valid <= 1'b0;
            r_pkt_sop   <= 1'b0;
            r_pkt_eop   <= 1'b0;
            r_pkt_empty <= '0;
            r_pkt_err   <= 1'b0;
            r_pkt_cnt   <= '0;
            r_err_cnt   <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_acc   <= w_acc_nx;
            r_lane  <= w_lane_nx;
            r_len   <= w_len_nx;
            r_first <= w_first_nx;
            if (w_load) begin
                r_pkt_valid <= 1'b1;
                r_pkt_data  <= w_beat_data;
                r_pkt_sop   <= w_beat_sop;
                r_pkt_eop   <= w_beat_eop;
                r_pkt_empty <= w_beat_emp;
                r_pkt_err   <= w_beat_err;
            end else if (pkt_ready) begin
                r_pkt_valid <= 1'b0;
            end
            if (w_eop_hs) begin
                r_pkt_cnt <= f_sat_inc(r_pkt_cnt);
                if (r_pkt_err) r_err_cnt <= f_sat_inc(r_err_cnt);
            end
            if (w_drop) r_drop_cnt <= f_sat_inc(r_drop_cnt);
        end
    end

    assign receive_ready     = w_ready;
    assign pkt_data          = r_pkt_data;
    assign pkt_valid         = r_pkt_valid;
    assign pkt_startofpacket = r_pkt_sop;
    assign pkt_endofpacket   = r_pkt_eop;
    assign pkt_empty         = r_pkt_empty;
    assign pkt_error         = r_pkt_err;
    assign stat_pkt_cnt      = r_pkt_cnt;
    assign stat_err_cnt      = r_err_cnt;
    assign stat_drop_cnt     = r_drop_cnt;

endmodule
